// File: rtl/pipe_mem_pkg.sv
// Shared types and default sizing for the shared-memory-port arbiter.
package pipe_mem_pkg;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_CW      = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        RESP     = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Cycle counter for a pending memory transaction.
// The hit output flags the last cycle before the transaction is abandoned.
module arb_timeout_cnt
    import pipe_mem_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CW      = DEF_CW
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_mem_arb.sv
// Arbiter/sequencer for the CPU's single memory port: data access beats fetch,
// one transaction at a time, with a timeout guard against a dead memory.
module pipe_mem_arb
    import pipe_mem_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CW      = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          IFreq,
    input  logic [AW-1:0] IFaddr,
    output logic [DW-1:0] IFrdata,
    output logic          IFack,
    output logic          IFstall,
    input  logic          MEMreq,
    input  logic          MEMwe,
    input  logic [AW-1:0] MEMaddr,
    input  logic [DW-1:0] MEMwdata,
    output logic [DW-1:0] MEMrdata,
    output logic          MEMack,
    output logic          MEMstall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err
);

    arb_state_e    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          dm_ack_q, dm_ack_d;
    logic          err_q, err_d;

    logic          busy;
    logic          cnt_hit;
    logic          finish;
    logic [DW-1:0] resp_data;
    owner_e        owner;

    assign busy  = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
    assign owner = (state_q == BUSY_MEM) ? OWN_MEM : OWN_IF;

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (!busy),
        .enable (busy),
        .hit    (cnt_hit)
    );

    // A ready response wins over a timeout landing in the same cycle.
    always_comb begin
        finish    = 1'b0;
        resp_data = '0;
        if (busy) begin
            if (mem_ready) begin
                finish    = 1'b1;
                resp_data = mem_we_q ? '0 : mem_rdata;
            end else if (cnt_hit) begin
                finish    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (MEMreq) begin
                    state_d     = BUSY_MEM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MEMwe;
                    mem_addr_d  = MEMaddr;
                    mem_wdata_d = MEMwdata;
                end else if (IFreq) begin
                    state_d    = BUSY_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = IFaddr;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (finish) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (!mem_ready) begin
                        err_d = 1'b1;
                    end
                    if (owner == OWN_MEM) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = resp_data;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = resp_data;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign IFrdata   = if_rdata_q;
    assign MEMrdata  = dm_rdata_q;
    assign IFack     = if_ack_q;
    assign MEMack    = dm_ack_q;
    assign err       = err_q;
    assign IFstall   = IFreq & ~if_ack_q;
    assign MEMstall  = MEMreq & ~dm_ack_q;

endmodule

// File: tb/tb_pipe_mem_arb.sv
// Directed bench for pipe_mem_arb: a vector table of single transactions
// plus hand sequences for collision, back-to-back, reset and dropped request.
module tb_pipe_mem_arb;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        IFreq;
    logic [31:0] IFaddr;
    logic [31:0] IFrdata;
    logic        IFack;
    logic        IFstall;
    logic        MEMreq;
    logic        MEMwe;
    logic [31:0] MEMaddr;
    logic [31:0] MEMwdata;
    logic [31:0] MEMrdata;
    logic        MEMack;
    logic        MEMstall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pipe_mem_arb #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (TO),
        .CW      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .IFreq     (IFreq),
        .IFaddr    (IFaddr),
        .IFrdata   (IFrdata),
        .IFack     (IFack),
        .IFstall   (IFstall),
        .MEMreq    (MEMreq),
        .MEMwe     (MEMwe),
        .MEMaddr   (MEMaddr),
        .MEMwdata  (MEMwdata),
        .MEMrdata  (MEMrdata),
        .MEMack    (MEMack),
        .MEMstall  (MEMstall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts in an IDLE cycle; returns in the ack cycle with the request dropped.
    task automatic run_txn(input bit is_mem, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int delay,
                           input logic [31:0] rdata, input logic [31:0] exp_rdata,
                           input bit exp_err, input string tag, output int start_cyc);
        int exp_lat;
        int lat;
        bit got;
        exp_lat   = (delay < TO) ? delay + 2 : TO + 1;
        lat       = 0;
        got       = 1'b0;
        start_cyc = -1;
        if (is_mem) begin
            MEMreq = 1'b1; MEMwe = we; MEMaddr = addr; MEMwdata = wdata;
        end else begin
            IFreq = 1'b1; IFaddr = addr;
        end
        for (int c = 1; c <= 20 && !got; c++) begin
            step();
            mem_ready = 1'b0;
            if (c == 1) begin
                start_cyc = cyc;
                chk({tag, ".mem_req"}, {31'd0, mem_req}, 32'd1);
                chk({tag, ".mem_addr"}, mem_addr, addr);
                chk({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, is_mem & we});
                if (is_mem && we) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
                chk({tag, ".stall_busy"}, {31'd0, is_mem ? MEMstall : IFstall}, 32'd1);
            end
            if (is_mem ? MEMack : IFack) begin
                got = 1'b1;
                lat = c;
                chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
                chk({tag, ".rdata"}, is_mem ? MEMrdata : IFrdata, exp_rdata);
                chk({tag, ".other_ack"}, {31'd0, is_mem ? IFack : MEMack}, 32'd0);
                chk({tag, ".stall_ack"}, {31'd0, is_mem ? MEMstall : IFstall}, 32'd0);
                chk({tag, ".mem_req_resp"}, {31'd0, mem_req}, 32'd0);
                chk({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
            end else if (c - 1 == delay) begin
                mem_ready = 1'b1;
                mem_rdata = rdata;
            end
        end
        chk({tag, ".ack_seen"}, {31'd0, got}, 32'd1);
        $display("txn %s start=%0d lat=%0d IFrdata=%0h MEMrdata=%0h err=%0b",
                 tag, start_cyc, lat, IFrdata, MEMrdata, err);
        if (is_mem) MEMreq = 1'b0;
        else        IFreq  = 1'b0;
    endtask

    initial begin
        int s1;
        int s2;
        int acks;

        vecs[0] = '{0, 0, 32'h100, 32'h0,    2,   32'hDEADBEEF, 32'hDEADBEEF, 0};
        vecs[1] = '{1, 0, 32'h300, 32'h0,    0,   32'h12345678, 32'h12345678, 0};
        vecs[2] = '{1, 1, 32'h304, 32'hA5A5, 1,   32'hFFFF,     32'h0,        0};
        vecs[3] = '{0, 0, 32'h108, 32'h0,    TO-1, 32'hCAFE,    32'hCAFE,     0};
        vecs[4] = '{0, 0, 32'h10C, 32'h0,    99,  32'h0BAD,     32'h0,        1};
        vecs[5] = '{1, 0, 32'h308, 32'h0,    0,   32'h600D,     32'h600D,     1};

        rst = 1'b1; IFreq = 1'b0; IFaddr = '0; MEMreq = 1'b0; MEMwe = 1'b0;
        MEMaddr = '0; MEMwdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        step();
        step();
        chk("rst.mem_req",   {31'd0, mem_req}, 32'd0);
        chk("rst.mem_we",    {31'd0, mem_we},  32'd0);
        chk("rst.IFack",     {31'd0, IFack},   32'd0);
        chk("rst.MEMack",    {31'd0, MEMack},  32'd0);
        chk("rst.err",       {31'd0, err},     32'd0);
        chk("rst.mem_addr",  mem_addr,  32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.IFrdata",   IFrdata,   32'd0);
        chk("rst.MEMrdata",  MEMrdata,  32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].is_mem, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].delay, vecs[i].rdata, vecs[i].exp_rdata,
                    vecs[i].exp_err, $sformatf("vec%0d", i), s1);
            step();
        end

        IFreq = 1'b1; IFaddr = 32'h1F0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rstmid.mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstmid.IFack",   {31'd0, IFack},   32'd0);
        chk("rstmid.err",     {31'd0, err},     32'd0);
        rst = 1'b0; IFreq = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h7777;
        step();
        mem_ready = 1'b0;
        chk("late_ready.IFack", {31'd0, IFack}, 32'd0);
        step();
        chk("late_ready.IFack2",  {31'd0, IFack},   32'd0);
        chk("late_ready.MEMack",  {31'd0, MEMack},  32'd0);
        chk("late_ready.mem_req", {31'd0, mem_req}, 32'd0);
        $display("txn rstmid mem_req=%0b IFack=%0b err=%0b", mem_req, IFack, err);

        IFreq = 1'b1; IFaddr = 32'h400;
        run_txn(1, 1, 32'h200, 32'h55, 1, 32'h999, 32'h0, 0, "coll.mem", s1);
        chk("coll.if_stall_wait", {31'd0, IFstall}, 32'd1);
        step();
        run_txn(0, 0, 32'h400, 32'h0, 0, 32'h77, 32'h77, 0, "coll.if", s2);
        step();

        run_txn(0, 0, 32'h500, 32'h0, 0, 32'hA1, 32'hA1, 0, "b2b.0", s1);
        step();
        run_txn(0, 0, 32'h504, 32'h0, 0, 32'hA2, 32'hA2, 0, "b2b.1", s2);
        chk("b2b.spacing", 32'(s2 - s1), 32'd3);
        step();

        IFreq = 1'b1; IFaddr = 32'h600;
        step();
        chk("drop.mem_req", {31'd0, mem_req}, 32'd1);
        IFreq = 1'b0;
        step();
        mem_ready = 1'b1; mem_rdata = 32'h1234;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            mem_ready = 1'b0;
            if (IFack) begin
                acks++;
                chk("drop.rdata", IFrdata, 32'h1234);
            end
        end
        chk("drop.ack_count", 32'(acks), 32'd1);
        chk("drop.idle_req",  {31'd0, mem_req}, 32'd0);
        $display("txn drop acks=%0d mem_req=%0b", acks, mem_req);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
